mul_sequencer: RTL and testbench

- Iterative multi-cycle integer multiplier on the DPUS datapath.
- Sits directly downstream of the decode stage. It consumes the DPUSControl code and the Mul indication, and produces the primary result plus the auxiliary (high-word) result written when AuxW is set.
- Radix-2 shift-add engine with start/done handshake. The main FSM holds in its execute state while Busy is high.

---
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_sequencer.sv | 152 +++++++++++++++
 tb/tb_mul_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Handshake and data bundle for mul_sequencer: request operands in, product and flags out.
interface mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [3:0]       DPUSControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] AuxResult;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic             MulN;
  logic             MulZ;

  modport master (
    output Start, DPUSControl, SrcA, SrcB,
    input  Result, AuxResult, Busy, Done, Err, MulN, MulZ
  );

  modport slave (
    input  Start, DPUSControl, SrcA, SrcB,
    output Result, AuxResult, Busy, Done, Err, MulN, MulZ
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier (MUL / UMULL / SMULL) with start/done handshake.
// Optional macro MUL_EARLY_EXIT_EN ends the iteration once the multiplier runs out of set bits.
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OpMul   = 4'b0100;
  localparam logic [3:0] OpUmull = 4'b0101;
  localparam logic [3:0] OpSmull = 4'b0111;

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   aux_q, aux_d;
  logic               err_q, err_d;
  logic               muln_q, muln_d;
  logic               mulz_q, mulz_d;

  logic               supported;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic               calc_last;

  assign supported = (bus.DPUSControl == OpMul) || (bus.DPUSControl == OpUmull) ||
                     (bus.DPUSControl == OpSmull);
  // Negating 0x8000_0000 wraps back to itself, which is the correct unsigned magnitude.
  assign abs_a = bus.SrcA[WIDTH-1] ? -bus.SrcA : bus.SrcA;
  assign abs_b = bus.SrcB[WIDTH-1] ? -bus.SrcB : bus.SrcB;
  assign prod  = neg_q ? -acc_q : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  assign calc_last = (cnt_q == CW'(WIDTH - 1)) || (mplr_q[WIDTH-1:1] == '0);
`else
  assign calc_last = (cnt_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    aux_d    = aux_q;
    err_d    = err_q;
    muln_d   = muln_q;
    mulz_d   = mulz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          if (supported) begin
            op_d  = bus.DPUSControl;
            acc_d = '0;
            cnt_d = '0;
            if (bus.DPUSControl == OpSmull) begin
              mcand_d = {{WIDTH{1'b0}}, abs_a};
              mplr_d  = abs_b;
              neg_d   = bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1];
            end else begin
              mcand_d = {{WIDTH{1'b0}}, bus.SrcA};
              mplr_d  = bus.SrcB;
              neg_d   = 1'b0;
            end
            state_d = StCalc;
          end else begin
            result_d = '0;
            aux_d    = '0;
            err_d    = 1'b1;
            muln_d   = 1'b0;
            mulz_d   = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StCalc: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (calc_last) state_d = StSign;
      end
      StSign: begin
        acc_d    = prod;
        result_d = prod[WIDTH-1:0];
        err_d    = 1'b0;
        if (op_q == OpMul) begin
          aux_d  = '0;
          muln_d = prod[WIDTH-1];
          mulz_d = (prod[WIDTH-1:0] == '0);
        end else begin
          aux_d  = prod[2*WIDTH-1:WIDTH];
          muln_d = prod[2*WIDTH-1];
          mulz_d = (prod == '0);
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      aux_q    <= '0;
      err_q    <= 1'b0;
      muln_q   <= 1'b0;
      mulz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      aux_q    <= aux_d;
      err_q    <= err_d;
      muln_q   <= muln_d;
      mulz_q   <= mulz_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.AuxResult = aux_q;
  assign bus.Err       = err_q;
  assign bus.MulN      = muln_q;
  assign bus.MulZ      = mulz_q;
  assign bus.Busy      = (state_q == StCalc) || (state_q == StSign);
  assign bus.Done      = (state_q == StDone);
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: issued requests push model results, a monitor checks on Done.
module tb_mul_sequencer;
  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] res;
    logic [31:0] aux;
    logic        err;
    logic        n;
    logic        z;
    int          k;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  logic busy_seen;
  exp_t sb_q[$];

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of each op.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int k);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    logic [31:0] m;
    int          hb;
    e.k = k;
    if (op != 4'b0100 && op != 4'b0101 && op != 4'b0111) begin
      e.res = '0; e.aux = '0; e.err = 1'b1; e.n = 1'b0; e.z = 1'b1; e.lat = 0;
      return e;
    end
    if (op == 4'b0111) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = 64'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    e.err = 1'b0;
    e.res = p[31:0];
    if (op == 4'b0100) begin
      e.aux = '0;
      e.n   = p[31];
      e.z   = (p[31:0] == 0);
    end else begin
      e.aux = p[63:32];
      e.n   = p[63];
      e.z   = (p == 0);
    end
`ifdef MUL_EARLY_EXIT_EN
    m  = (op == 4'b0111 && b[31]) ? -b : b;
    hb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hb = i;
    e.lat = hb + 2;
`else
    m     = b;
    hb    = 0;
    e.lat = 33;
`endif
    return e;
  endfunction

  // Monitor: compare every Done against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.Busy) busy_seen = 1'b1;
      if (bus.Done) begin
        check("busy_with_done", {63'b0, bus.Busy}, 64'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 want no done");
        end else begin
          e = sb_q.pop_front();
          check("result", {32'b0, bus.Result}, {32'b0, e.res});
          check("aux", {32'b0, bus.AuxResult}, {32'b0, e.aux});
          check("err", {63'b0, bus.Err}, {63'b0, e.err});
          check("muln", {63'b0, bus.MulN}, {63'b0, e.n});
          check("mulz", {63'b0, bus.MulZ}, {63'b0, e.z});
          check("latency", 64'(cyc - e.k), 64'(e.lat));
          if (e.err) check("err_busy", {63'b0, busy_seen}, 64'd0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, {32'b0, bus.Result}, 64'd0);
    check({tag, "_aux"}, {32'b0, bus.AuxResult}, 64'd0);
    check({tag, "_busy"}, {63'b0, bus.Busy}, 64'd0);
    check({tag, "_done"}, {63'b0, bus.Done}, 64'd0);
    check({tag, "_err"}, {63'b0, bus.Err}, 64'd0);
    check({tag, "_muln"}, {63'b0, bus.MulN}, 64'd0);
    check({tag, "_mulz"}, {63'b0, bus.MulZ}, 64'd0);
  endtask

  // Drive one request for the edge after the current one; operands scrambled afterwards.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    busy_seen       = 1'b0;
    bus.Start       = 1'b1;
    bus.DPUSControl = op;
    bus.SrcA        = a;
    bus.SrcB        = b;
    sb_q.push_back(model(op, a, b, cyc + 1));
    @(posedge clk);
    #1;
    bus.Start       = 1'b0;
    bus.DPUSControl = 4'($urandom);
    bus.SrcA        = $urandom;
    bus.SrcB        = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.Done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got done=0 want done within 60 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    wait_done();
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          r;
    cyc             = 0;
    checks          = 0;
    errors          = 0;
    busy_seen       = 1'b0;
    bus.Start       = 1'b0;
    bus.DPUSControl = '0;
    bus.SrcA        = '0;
    bus.SrcB        = '0;
    reset           = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    run(4'b0100, 32'd7, 32'd6);
    run(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(4'b0111, 32'hFFFF_FFFD, 32'd5);
    run(4'b0111, 32'h8000_0000, 32'h8000_0000);
    run(4'b1011, 32'd3, 32'd4);
    run(4'b1001, 32'hDEAD_BEEF, 32'h1234_5678);
    run(4'b0100, 32'd9, 32'd0);
    run(4'b0111, 32'h1234_5678, 32'hFFFF_FFFF);

    // Re-pulse Start while busy: must be ignored, original product delivered.
    issue(4'b0101, 32'hCAFE_F00D, 32'h8765_4321);
    repeat (2) @(posedge clk);
    #1;
    if (bus.Busy) begin
      bus.Start       = 1'b1;
      bus.DPUSControl = 4'b0100;
      bus.SrcA        = 32'd1;
      bus.SrcB        = 32'd1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
    end
    wait_done();

    // Abort mid-calculation: outputs clear at once and no Done follows.
    issue(4'b0101, 32'h0F0F_0F0F, 32'hF000_0001);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) op = 4'b0100;
      else if (r < 6) op = 4'b0101;
      else if (r < 9) op = 4'b0111;
      else op = 4'($urandom);
      a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 4) == 0) b = -b;
      run(op, a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
